// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcodes, enums and the decoded packet type for the decode stage
package decode_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // The packet carries the widest PC we support; the stage truncates to PC_W.
  localparam int PC_MAX_W = 32;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    FU_ALU    = 2'b00,
    FU_BRANCH = 2'b01,
    FU_LSU    = 2'b10
  } fu_type_e;

  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_OP     = 2'b10,
    ALUOP_PASS   = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic [PC_MAX_W-1:0] pc;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [31:0]         imm;
    logic                alu_src;
    logic                branch;
    logic                mem_read;
    logic                mem_write;
    logic                reg_write;
    alu_op_e             alu_op;
    fu_type_e            fu_type;
    logic [2:0]          funct3;
    logic                funct7b5;
    logic                illegal;
  } decoded_t;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch-side and rename-side handshake bundle of the decode stage
interface decode_stage_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 9
);

  logic [31:0]     instruction;
  logic [PC_W-1:0] i_pc;
  logic            i_valid;
  logic            o_ready;
  logic            i_ready;
  logic            o_valid;
  logic [PC_W-1:0] o_pc;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] immediate;
  logic            ALUsrc;
  logic            Branch;
  logic            Memread;
  logic            Memwrite;
  logic            Regwrite;
  logic [1:0]      ALUOp;
  logic [1:0]      FUtype;
  logic [2:0]      funct3;
  logic            funct7b5;
  logic            illegal;

  modport slave (
    input  instruction, i_pc, i_valid, i_ready,
    output o_ready, o_valid, o_pc, rs1, rs2, rd, immediate,
           ALUsrc, Branch, Memread, Memwrite, Regwrite,
           ALUOp, FUtype, funct3, funct7b5, illegal
  );

  modport master (
    output instruction, i_pc, i_valid, i_ready,
    input  o_ready, o_valid, o_pc, rs1, rs2, rd, immediate,
           ALUsrc, Branch, Memread, Memwrite, Regwrite,
           ALUOp, FUtype, funct3, funct7b5, illegal
  );

endinterface

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational RV32I instruction to decoded_t translation
module instr_decode
  import decode_pkg::*;
#(
  parameter int PC_W = 9
) (
  input  logic [31:0]     instruction,
  input  logic [PC_W-1:0] pc,
  output decoded_t        dec
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        legal;
  logic        use_rs1, use_rs2, use_rd, keep_f3;
  decoded_t    d;

  assign opcode = instruction[6:0];
  assign f3     = instruction[14:12];
  assign f7     = instruction[31:25];

  assign imm_i = sext12(instruction[31:20]);
  assign imm_s = sext12({instruction[31:25], instruction[11:7]});
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u = {instruction[31:12], 12'b0};
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};

  always_comb begin
    d        = '0;
    d.pc     = PC_MAX_W'(pc);
    legal    = 1'b1;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    use_rd   = 1'b0;
    keep_f3  = 1'b1;

    case (opcode)
      OPC_OP: begin
        legal      = (f7 == FUNCT7_BASE) ||
                     ((f7 == FUNCT7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        use_rd     = 1'b1;
        d.alu_op   = ALUOP_OP;
        d.fu_type  = FU_ALU;
        d.funct7b5 = instruction[30];
      end
      OPC_OP_IMM: begin
        legal      = !((f3 == 3'b001) && (f7 != FUNCT7_BASE)) &&
                     !((f3 == 3'b101) && (f7 != FUNCT7_BASE) && (f7 != FUNCT7_ALT));
        use_rs1    = 1'b1;
        use_rd     = 1'b1;
        d.alu_src  = 1'b1;
        d.alu_op   = ALUOP_OP;
        d.fu_type  = FU_ALU;
        d.imm      = imm_i;
        // Only the right-shift family distinguishes SRLI/SRAI via bit 30.
        d.funct7b5 = (f3 == 3'b101) ? instruction[30] : 1'b0;
      end
      OPC_LOAD: begin
        legal      = !((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111));
        use_rs1    = 1'b1;
        use_rd     = 1'b1;
        d.alu_src  = 1'b1;
        d.mem_read = 1'b1;
        d.fu_type  = FU_LSU;
        d.imm      = imm_i;
      end
      OPC_STORE: begin
        legal       = (f3 <= 3'b010);
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
        d.alu_src   = 1'b1;
        d.mem_write = 1'b1;
        d.fu_type   = FU_LSU;
        d.imm       = imm_s;
      end
      OPC_BRANCH: begin
        legal     = !((f3 == 3'b010) || (f3 == 3'b011));
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        d.branch  = 1'b1;
        d.alu_op  = ALUOP_BRANCH;
        d.fu_type = FU_BRANCH;
        d.imm     = imm_b;
      end
      OPC_LUI: begin
        use_rd    = 1'b1;
        keep_f3   = 1'b0;
        d.alu_src = 1'b1;
        d.alu_op  = ALUOP_PASS;
        d.fu_type = FU_ALU;
        d.imm     = imm_u;
      end
      OPC_AUIPC: begin
        use_rd    = 1'b1;
        keep_f3   = 1'b0;
        d.alu_src = 1'b1;
        d.alu_op  = ALUOP_ADD;
        d.fu_type = FU_ALU;
        d.imm     = imm_u;
      end
      OPC_JAL: begin
        use_rd    = 1'b1;
        keep_f3   = 1'b0;
        d.alu_src = 1'b1;
        d.branch  = 1'b1;
        d.fu_type = FU_BRANCH;
        d.imm     = imm_j;
      end
      OPC_JALR: begin
        legal     = (f3 == 3'b000);
        use_rs1   = 1'b1;
        use_rd    = 1'b1;
        d.alu_src = 1'b1;
        d.branch  = 1'b1;
        d.fu_type = FU_BRANCH;
        d.imm     = imm_i;
      end
      default: legal = 1'b0;
    endcase

    d.rs1       = use_rs1 ? instruction[19:15] : 5'd0;
    d.rs2       = use_rs2 ? instruction[24:20] : 5'd0;
    d.rd        = use_rd  ? instruction[11:7]  : 5'd0;
    d.funct3    = keep_f3 ? f3 : 3'b000;
    d.reg_write = use_rd && (instruction[11:7] != 5'd0);

    // Illegal packets keep only their PC so commit can still trap precisely.
    if (!legal) begin
      d         = '0;
      d.pc      = PC_MAX_W'(pc);
      d.illegal = 1'b1;
    end
  end

  assign dec = d;

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage with a 2-entry registered skid buffer
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 9
) (
  input logic           clk,
  input logic           rst,
  input logic           flush,
  decode_stage_if.slave bus
);

  if (XLEN != 32) begin : g_xlen_check
    $error("decode_stage: XLEN must be 32");
  end
  if (PC_W > PC_MAX_W) begin : g_pc_check
    $error("decode_stage: PC_W exceeds PC_MAX_W");
  end

  typedef enum logic [1:0] {
    CNT_0 = 2'd0,
    CNT_1 = 2'd1,
    CNT_2 = 2'd2
  } count_e;

  count_e   count_q, count_d;
  decoded_t dec;
  decoded_t head_q, tail_q;
  logic     push, pop;
  logic     load_head, shift_tail, load_tail;

  instr_decode #(.PC_W(PC_W)) u_instr_decode (
    .instruction (bus.instruction),
    .pc          (bus.i_pc),
    .dec         (dec)
  );

  // o_ready depends only on local state, never on i_ready.
  assign bus.o_ready = (count_q != CNT_2) && !rst;
  assign bus.o_valid = (count_q != CNT_0);

  assign push = bus.i_valid && bus.o_ready && !flush;
  assign pop  = bus.o_valid && bus.i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= CNT_0;
    end else begin
      count_q <= count_d;
    end
  end

  always_comb begin
    count_d    = count_q;
    load_head  = 1'b0;
    shift_tail = 1'b0;
    load_tail  = 1'b0;
    if (flush) begin
      count_d = CNT_0;
    end else begin
      case (count_q)
        CNT_0: begin
          if (push) begin
            load_head = 1'b1;
            count_d   = CNT_1;
          end
        end
        CNT_1: begin
          case ({push, pop})
            2'b11: load_head = 1'b1;
            2'b10: begin
              load_tail = 1'b1;
              count_d   = CNT_2;
            end
            2'b01: count_d = CNT_0;
            default: ;
          endcase
        end
        CNT_2: begin
          if (pop) begin
            shift_tail = 1'b1;
            if (push) begin
              load_tail = 1'b1;
            end else begin
              count_d = CNT_1;
            end
          end
        end
        default: count_d = CNT_0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (load_head) begin
        head_q <= dec;
      end else if (shift_tail) begin
        head_q <= tail_q;
      end
      if (load_tail) begin
        tail_q <= dec;
      end
    end
  end

  assign bus.o_pc      = head_q.pc[PC_W-1:0];
  assign bus.rs1       = head_q.rs1;
  assign bus.rs2       = head_q.rs2;
  assign bus.rd        = head_q.rd;
  assign bus.immediate = head_q.imm;
  assign bus.ALUsrc    = head_q.alu_src;
  assign bus.Branch    = head_q.branch;
  assign bus.Memread   = head_q.mem_read;
  assign bus.Memwrite  = head_q.mem_write;
  assign bus.Regwrite  = head_q.reg_write;
  assign bus.ALUOp     = head_q.alu_op;
  assign bus.FUtype    = head_q.fu_type;
  assign bus.funct3    = head_q.funct3;
  assign bus.funct7b5  = head_q.funct7b5;
  assign bus.illegal   = head_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed and random checks of decode_stage against a reference model
module tb_decode_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32), .PC_W(9)) bus ();

  decode_stage #(.XLEN(32), .PC_W(9)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct packed {
    logic [8:0]  pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        alusrc, branch, memread, memwrite, regwrite;
    logic [1:0]  aluop, futype;
    logic [2:0]  f3;
    logic        f7b5;
    logic        ill;
  } pkt_t;

  pkt_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  logic [8:0] pc_ctr = 9'h004;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic pkt_t observe();
    pkt_t p;
    p.pc = bus.o_pc; p.rs1 = bus.rs1; p.rs2 = bus.rs2; p.rd = bus.rd;
    p.imm = bus.immediate; p.alusrc = bus.ALUsrc; p.branch = bus.Branch;
    p.memread = bus.Memread; p.memwrite = bus.Memwrite; p.regwrite = bus.Regwrite;
    p.aluop = bus.ALUOp; p.futype = bus.FUtype; p.f3 = bus.funct3;
    p.f7b5 = bus.funct7b5; p.ill = bus.illegal;
    return p;
  endfunction

  // Reference decode: each opcode is described by which fields it uses and its flags.
  function automatic pkt_t ref_decode(input logic [31:0] ins, input logic [8:0] pc);
    pkt_t p;
    logic [2:0] f3;
    logic [6:0] f7;
    logic ok, has_rs1, has_rs2, has_rd, has_f3;
    logic signed [31:0] w;
    p = '0;
    f3 = ins[14:12];
    f7 = ins[31:25];
    ok = 1'b1; has_rs1 = 0; has_rs2 = 0; has_rd = 0; has_f3 = 1;
    case (ins[6:0])
      7'h33: begin
        ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        has_rs1 = 1; has_rs2 = 1; has_rd = 1; p.aluop = 2; p.futype = 0; p.f7b5 = ins[30];
      end
      7'h13: begin
        ok = !(f3 == 1 && f7 != 0) && !(f3 == 5 && f7 != 0 && f7 != 7'h20);
        has_rs1 = 1; has_rd = 1; p.alusrc = 1; p.aluop = 2;
        w = $signed(ins) >>> 20; p.imm = w; p.f7b5 = (f3 == 5) ? ins[30] : 1'b0;
      end
      7'h03: begin
        ok = !(f3 == 3 || f3 == 6 || f3 == 7);
        has_rs1 = 1; has_rd = 1; p.alusrc = 1; p.memread = 1; p.futype = 2;
        w = $signed(ins) >>> 20; p.imm = w;
      end
      7'h23: begin
        ok = f3 < 3;
        has_rs1 = 1; has_rs2 = 1; p.alusrc = 1; p.memwrite = 1; p.futype = 2;
        w = $signed({ins[31:25], ins[11:7], 20'b0}) >>> 20; p.imm = w;
      end
      7'h63: begin
        ok = !(f3 == 2 || f3 == 3);
        has_rs1 = 1; has_rs2 = 1; p.branch = 1; p.aluop = 1; p.futype = 1;
        w = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0, 19'b0}) >>> 19; p.imm = w;
      end
      7'h37: begin
        has_rd = 1; has_f3 = 0; p.alusrc = 1; p.aluop = 3; p.imm = ins & 32'hFFFFF000;
      end
      7'h17: begin
        has_rd = 1; has_f3 = 0; p.alusrc = 1; p.aluop = 0; p.imm = ins & 32'hFFFFF000;
      end
      7'h6F: begin
        has_rd = 1; has_f3 = 0; p.alusrc = 1; p.branch = 1; p.futype = 1;
        w = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0, 11'b0}) >>> 11; p.imm = w;
      end
      7'h67: begin
        ok = (f3 == 0);
        has_rs1 = 1; has_rd = 1; p.alusrc = 1; p.branch = 1; p.futype = 1;
        w = $signed(ins) >>> 20; p.imm = w;
      end
      default: ok = 1'b0;
    endcase
    if (has_rs1) p.rs1 = ins[19:15];
    if (has_rs2) p.rs2 = ins[24:20];
    if (has_rd)  p.rd  = ins[11:7];
    if (has_f3)  p.f3  = f3;
    p.regwrite = has_rd && (ins[11:7] != 0);
    if (!ok) begin
      p = '0;
      p.ill = 1'b1;
    end
    p.pc = pc;
    return p;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [9];
    logic [31:0] r;
    int k;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
    r = $urandom;
    k = $urandom_range(0, 11);
    if (k < 9) begin
      r[6:0] = ops[k];
      if ($urandom_range(0, 3) != 0) r[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
      if ($urandom_range(0, 3) == 0) r[11:7] = 5'd0;
    end
    return r;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_o_valid"}, 128'(bus.o_valid), 128'(q.size() > 0));
    check({tag, "_o_ready"}, 128'(bus.o_ready), 128'(q.size() < 2));
    if (q.size() > 0) check({tag, "_packet"}, 128'(observe()), 128'(q[0]));
  endtask

  // One clock: drive at the falling edge, update the model on the rising edge, check after.
  task automatic step(input logic v, input logic [31:0] ins, input logic rdy, input logic fl,
                      input string tag);
    logic push, pop;
    logic [8:0] pc;
    pc = pc_ctr;
    bus.i_valid = v; bus.instruction = ins; bus.i_pc = pc; bus.i_ready = rdy; flush = fl;
    push = v && (q.size() < 2) && !fl;
    pop  = (q.size() > 0) && rdy;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(ref_decode(ins, pc));
        pc_ctr = pc_ctr + 9'd4;
      end
    end
    @(negedge clk);
    bus.i_valid = 1'b0;
    flush = 1'b0;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    bus.i_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    q.delete();
    check({tag, "_rst_o_ready"}, 128'(bus.o_ready), 128'(0));
    check({tag, "_rst_o_valid"}, 128'(bus.o_valid), 128'(0));
    check({tag, "_rst_data"}, 128'(observe()), 128'(0));
    rst = 1'b0;
    #1;
    check({tag, "_post_rst_o_ready"}, 128'(bus.o_ready), 128'(1));
  endtask

  initial begin
    bus.i_valid = 1'b0; bus.instruction = '0; bus.i_pc = '0; bus.i_ready = 1'b0;
    @(negedge clk);
    do_reset("init");
    @(negedge clk);

    step(1, 32'h002081B3, 1, 0, "add");
    check("add_rs1", 128'(bus.rs1), 128'(1));
    check("add_rs2", 128'(bus.rs2), 128'(2));
    check("add_rd", 128'(bus.rd), 128'(3));
    check("add_aluop", 128'(bus.ALUOp), 128'(2));
    check("add_regwrite", 128'(bus.Regwrite), 128'(1));
    check("add_f7b5", 128'(bus.funct7b5), 128'(0));
    check("add_illegal", 128'(bus.illegal), 128'(0));

    step(1, 32'hFE208EE3, 1, 0, "beq");
    check("beq_imm", 128'(bus.immediate), 128'(32'hFFFFFFFC));
    check("beq_branch", 128'(bus.Branch), 128'(1));
    check("beq_futype", 128'(bus.FUtype), 128'(1));
    check("beq_rd", 128'(bus.rd), 128'(0));
    check("beq_regwrite", 128'(bus.Regwrite), 128'(0));

    step(1, 32'h00812283, 1, 0, "lw");
    check("lw_imm", 128'(bus.immediate), 128'(8));
    check("lw_memread", 128'(bus.Memread), 128'(1));
    check("lw_futype", 128'(bus.FUtype), 128'(2));
    check("lw_rd", 128'(bus.rd), 128'(5));
    step(1, 32'h00000013, 1, 0, "nop");
    check("nop_regwrite", 128'(bus.Regwrite), 128'(0));

    pc_ctr = 9'h1AB;
    step(1, 32'hFFFFFFFF, 1, 0, "ill");
    check("ill_flag", 128'(bus.illegal), 128'(1));
    check("ill_pc", 128'(bus.o_pc), 128'(9'h1AB));
    check("ill_ctrl", 128'({bus.ALUsrc, bus.Branch, bus.Memread, bus.Memwrite, bus.Regwrite,
                            bus.ALUOp, bus.FUtype, bus.funct3, bus.funct7b5}), 128'(0));
    check("ill_imm", 128'(bus.immediate), 128'(0));
    step(0, 32'h0, 1, 0, "drain");

    // Back-pressure: third instruction must wait until rename drains the buffer.
    step(1, 32'h00500093, 0, 0, "bp1");
    step(1, 32'h00A00113, 0, 0, "bp2");
    check("bp_full_o_ready", 128'(bus.o_ready), 128'(0));
    step(1, 32'h00F00193, 0, 0, "bp3_blocked");
    step(1, 32'h00F00193, 1, 0, "bp3_pop");
    step(0, 32'h0, 1, 0, "bp_drain1");
    step(0, 32'h0, 1, 0, "bp_drain2");
    step(0, 32'h0, 1, 0, "bp_drain3");

    step(1, 32'h40208033, 0, 0, "fl_fill1");
    step(1, 32'h4050D093, 0, 0, "fl_fill2");
    step(1, 32'h12345037, 0, 1, "flush");
    check("flush_o_valid", 128'(bus.o_valid), 128'(0));
    step(0, 32'h0, 1, 0, "post_flush1");
    step(0, 32'h0, 1, 0, "post_flush2");

    step(1, 32'h0000A103, 0, 0, "rs_fill1");
    step(1, 32'h00112423, 0, 0, "rs_fill2");
    do_reset("mid");
    @(negedge clk);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 24) == 0, "rand");
    end
    for (int i = 0; i < 3; i++) step(0, 32'h0, 1, 0, "final_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised RV32I decode stage that sits between the fetch skid buffer and the rename stage. It accepts one instruction per cycle over a valid/ready handshake and decodes it into a control packet. The packet is held in an internal 2-entry skid buffer, so that `o_ready` has no combinational path from `i_ready`. Beyond plain field extraction, the stage:

- detects illegal encodings,
- suppresses writes to x0,
- forwards `funct3`/`funct7[5]` for ALU/LSU/branch sub-op selection,
- supports a pipeline flush.

## Interface
Parameters:
- `XLEN`, 32: data/immediate width; only 32 is legal (elaboration error otherwise).
- `PC_W`, 9: PC width carried alongside the instruction.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous squash of all held and incoming instructions.
- `instruction`  in  32  raw instruction from fetch.
- `i_pc`  in  `PC_W`  PC of `instruction`.
- `i_valid`  in  1  `instruction`/`i_pc` valid.
- `o_ready`  out  1  stage can accept an instruction this cycle.
- `i_ready`  in  1  rename accepts the head packet this cycle.
- `o_valid`  out  1  head packet valid.
- `o_pc`  out  `PC_W`  PC of the head packet.
- `rs1`, `rs2`, `rd`  out  5 each  register indices; 0 when the format has no such field.
- `immediate`  out  `XLEN`  sign-extended immediate per format (I/S/B/U/J); 0 for R-type.
- `ALUsrc`, `Branch`, `Memread`, `Memwrite`, `Regwrite`  out  1 each  control flags.
- `ALUOp`  out  2  00 add, 01 branch compare, 10 R/I ALU op, 11 pass immediate.
- `FUtype`  out  2  00 ALU, 01 branch, 10 LSU.
- `funct3`  out  3  `instruction[14:12]`; 0 for LUI/AUIPC/JAL.
- `funct7b5`  out  1  `instruction[30]` for R-type and for OP-IMM funct3=101; otherwise 0.
- `illegal`  out  1  unsupported or malformed encoding.

## Operation
Per-opcode decode (combinational, applied at input):
- **R-type (0110011):** ALU, `ALUOp`=10, uses rs1/rs2/rd.
- **OP-IMM (0010011):** ALU, `ALUsrc`, `ALUOp`=10, uses rs1/rd.
- **LOAD (0000011):** LSU, `ALUsrc`, `Memread`, uses rs1/rd.
- **STORE (0100011):** LSU, `ALUsrc`, `Memwrite`, uses rs1/rs2.
- **BRANCH (1100011):** branch unit, `Branch`, `ALUOp`=01, uses rs1/rs2.
- **LUI:** ALU, `ALUsrc`, `ALUOp`=11, uses rd.
- **AUIPC:** ALU, `ALUsrc`, `ALUOp`=00, uses rd.
- **JAL:** branch unit, `ALUsrc`, `Branch`, uses rd.
- **JALR:** branch unit, `ALUsrc`, `Branch`, uses rs1/rd.
- `Regwrite`=1 for every opcode with an rd field, forced to 0 when rd==0.

`illegal`=1 for any of the following:
- Opcode outside the nine above.
- R-type with `funct7` not in {0000000, 0100000}, or `funct7`=0100000 with `funct3` not in {000, 101}.
- OP-IMM: `funct3`=001 with `funct7`≠0, or `funct3`=101 with `funct7` not in {0, 0100000}.
- LOAD with `funct3` in {011, 110, 111}.
- STORE with `funct3`>010.
- BRANCH with `funct3` in {010, 011}.
- JALR with `funct3`≠000.

An illegal packet has all control flags, `ALUOp`, `FUtype`, register fields, `funct3`, `funct7b5` and `immediate` equal to 0. It is still forwarded with its PC, so that commit can trap.

Skid buffer (2 entries, FIFO order; `count` is 0..2):
- Input is accepted when `i_valid & o_ready`; output is consumed when `o_valid & i_ready`.
- `o_ready` = (`count` < 2) & ~`rst`.
- `o_valid` = (`count` > 0).
- Outputs always show the oldest entry. With `count`=0, all data outputs hold their last value and must not be sampled.
- Simultaneous accept and consume at `count`=1 or 2: `count` unchanged, order preserved.
- Simultaneous accept and consume at `count`=0: the packet enters the buffer and is not bypassed.
- `flush`: next cycle `count`=0. An input offered in the flush cycle is dropped, even if `o_ready`=1.
- `rst` overrides `flush`.

## Timing
- Latency: an instruction accepted in cycle N is at the outputs with `o_valid`=1 in cycle N+1.
- Throughput: 1 per cycle while `i_ready` is held at 1.
- Reset: `count`=0, `o_valid`=0, and all data outputs are 0. `o_ready`=0 while `rst` is high and 1 in the first cycle after.
- Reset mid-operation discards both entries.
- The downstream `i_ready`-to-`o_ready` path is purely sequential.

## Structure
- Package `decode_pkg` holds:
  - opcode localparams;
  - `FUtype` and `ALUOp` enums;
  - the `decoded_t` packed struct (pc, regs, imm, flags, funct bits, illegal), stored in the buffer.
- Sub-module `instr_decode`: purely combinational, instruction → `decoded_t`.
- `decode_stage` = `instr_decode` + the 2-entry buffer and `count` register.

## Test plan
- `0x002081B3` (add x3,x1,x2), `i_ready`=1 → next cycle `rs1`=1, `rs2`=2, `rd`=3, `ALUOp`=10, `Regwrite`=1, `funct7b5`=0, `illegal`=0.
- `0xFE208EE3` (beq x1,x2,-4) → `immediate`=`0xFFFFFFFC`, `Branch`=1, `FUtype`=01, `rd`=0, `Regwrite`=0.
- `0x00812283` (lw x5,8(x2)) followed by `0x00000013` (addi x0,x0,0) → load: `immediate`=8, `Memread`=1, `FUtype`=10; addi: `Regwrite`=0 (rd=0).
- `0xFFFFFFFF` → `illegal`=1, all controls 0, `o_pc` preserved.
- Hold `i_ready`=0 and stream 3 instructions → `o_ready` drops after the second. Release `i_ready` → packets emerge in order with no loss.
- With `count`=2, assert `flush` together with `i_valid` → next cycle `o_valid`=0 and `count`=0; the flushed input never appears. Repeat with `rst` mid-stream → all outputs 0.
